i2c_poll_sequencer: RTL and testbench

I2C_POLL_SEQUENCER -- requirements
Module: i2c_poll_sequencer

---
 rtl/i2c_poll_sequencer.sv | 162 ++++++++++++++++
 tb/tb_i2c_poll_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_poll_sequencer.sv
// Periodic I2C poll sequencer: sweeps the enabled channels through one shared
// master and keeps the latest read result plus valid/error status per channel.
module i2c_poll_sequencer #(
  parameter int                  NUM_CH      = 8,
  parameter int                  DATA_W      = 8,
  parameter logic [7*NUM_CH-1:0] ADDR_TABLE  = {7'h47, 7'h46, 7'h45, 7'h44,
                                               7'h4B, 7'h4A, 7'h49, 7'h48},
  parameter int                  POLL_PERIOD = 1000,
  parameter int                  TIMEOUT     = 100000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic                     mst_ready,
  input  logic                     mst_done,
  input  logic                     mst_nack,
  input  logic [15:0]              mst_rdata,
  output logic                     mst_start,
  output logic [6:0]               mst_addr,
  output logic                     mst_rw,
  output logic                     mst_two_bytes,
  output logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_valid,
  output logic [NUM_CH-1:0]        ch_err,
  output logic                     sweep_done,
  output logic                     busy
);

  localparam int IDX_W = $clog2(NUM_CH + 1);
  localparam int PER_W = $clog2(POLL_PERIOD + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(NUM_CH);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(POLL_PERIOD - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_ISSUE,
    S_XFER,
    S_NEXT
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [IDX_W-1:0]    idx;
  logic [PER_W-1:0]    per_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [NUM_CH-1:0]   mask_lat;
  logic                mask_hit;
  logic [6:0]          addr_sel;
  logic                per_hit;
  logic                tmo_hit;
  logic                scan_end;
  logic [DATA_W-1:0]   rd_sel;
  logic                rdata_unused;

  // Channel lookup by the running index; idx == NUM_CH selects nothing.
  always_comb begin
    mask_hit = 1'b0;
    addr_sel = 7'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx == IDX_W'(i)) begin
        mask_hit = mask_lat[i];
        addr_sel = ADDR_TABLE[7*i +: 7];
      end
    end
  end

  assign per_hit      = (per_cnt == PER_LAST);
  assign tmo_hit      = (tmo_cnt == TMO_LAST);
  assign scan_end     = (idx == IDX_END);
  // Result is MSB-byte first, so an 8-bit channel keeps the upper byte.
  assign rd_sel       = mst_rdata[15 -: DATA_W];
  assign rdata_unused = ^mst_rdata;

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (enable && per_hit) state_nxt = S_SCAN;
      S_SCAN: begin
        if (scan_end)      state_nxt = S_IDLE;
        else if (mask_hit) state_nxt = S_ISSUE;
      end
      S_ISSUE: if (mst_ready) state_nxt = S_XFER;
      S_XFER:  if (mst_done || tmo_hit) state_nxt = S_NEXT;
      S_NEXT:  state_nxt = enable ? S_SCAN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != S_IDLE);
    mst_rw = busy;
  end

  assign mst_two_bytes = (DATA_W == 16);

  // Sequencing control: period/timeout counters, channel index, master request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      per_cnt    <= '0;
      tmo_cnt    <= '0;
      idx        <= '0;
      mask_lat   <= '0;
      mst_start  <= 1'b0;
      mst_addr   <= '0;
      sweep_done <= 1'b0;
    end else begin
      mst_start  <= (state == S_ISSUE) && mst_ready;
      sweep_done <= (state == S_SCAN) && scan_end;
      tmo_cnt    <= (state == S_XFER) ? tmo_cnt + 1'b1 : '0;
      if ((state == S_IDLE) && enable && !per_hit) per_cnt <= per_cnt + 1'b1;
      else                                         per_cnt <= '0;
      case (state)
        S_IDLE: begin
          if (enable && per_hit) begin
            mask_lat <= ch_mask;
            idx      <= '0;
          end
        end
        S_SCAN: begin
          if (!scan_end) begin
            if (mask_hit) mst_addr <= addr_sel;
            else          idx      <= idx + 1'b1;
          end
        end
        S_NEXT:  idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

  // Result capture: a completion in the timeout cycle still counts as a read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ch_data  <= '0;
      ch_valid <= '0;
      ch_err   <= '0;
    end else if ((state == S_XFER) && (mst_done || tmo_hit)) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (idx == IDX_W'(i)) begin
          if (mst_done && !mst_nack) begin
            ch_data[DATA_W*i +: DATA_W] <= rd_sel;
            ch_valid[i]                 <= 1'b1;
            ch_err[i]                   <= 1'b0;
          end else begin
            ch_valid[i] <= 1'b0;
            ch_err[i]   <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_poll_sequencer.sv
// Randomized bench for i2c_poll_sequencer: an 8-bit and a 16-bit instance share
// one master responder and are checked against a per-channel outcome model.
module tb_i2c_poll_sequencer;

  localparam int NUM_CH      = 8;
  localparam int POLL_PERIOD = 4;
  localparam int TIMEOUT     = 16;
  localparam logic [7*NUM_CH-1:0] ADDR_TABLE = {7'h47, 7'h46, 7'h45, 7'h44,
                                               7'h4B, 7'h4A, 7'h49, 7'h48};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable, mst_ready, mst_done, mst_nack;
  logic [7:0]  ch_mask;
  logic [15:0] mst_rdata;

  logic        start_a, rw_a, tb_a, swd_a, busy_a;
  logic [6:0]  addr_a;
  logic [63:0] data_a;
  logic [7:0]  valid_a, err_a;
  logic        start_b, rw_b, tb_b, swd_b, busy_b;
  logic [6:0]  addr_b;
  logic [127:0] data_b;
  logic [7:0]  valid_b, err_b;

  i2c_poll_sequencer #(.NUM_CH(NUM_CH), .DATA_W(8), .ADDR_TABLE(ADDR_TABLE),
                       .POLL_PERIOD(POLL_PERIOD), .TIMEOUT(TIMEOUT)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask),
    .mst_ready(mst_ready), .mst_done(mst_done), .mst_nack(mst_nack),
    .mst_rdata(mst_rdata), .mst_start(start_a), .mst_addr(addr_a),
    .mst_rw(rw_a), .mst_two_bytes(tb_a), .ch_data(data_a),
    .ch_valid(valid_a), .ch_err(err_a), .sweep_done(swd_a), .busy(busy_a)
  );

  i2c_poll_sequencer #(.NUM_CH(NUM_CH), .DATA_W(16), .ADDR_TABLE(ADDR_TABLE),
                       .POLL_PERIOD(POLL_PERIOD), .TIMEOUT(TIMEOUT)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask),
    .mst_ready(mst_ready), .mst_done(mst_done), .mst_nack(mst_nack),
    .mst_rdata(mst_rdata), .mst_start(start_b), .mst_addr(addr_b),
    .mst_rw(rw_b), .mst_two_bytes(tb_b), .ch_data(data_b),
    .ch_valid(valid_b), .ch_err(err_b), .sweep_done(swd_b), .busy(busy_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Outcome model: last good word, valid and error per channel.
  logic [15:0] m_data [NUM_CH];
  logic [7:0]  m_valid, m_err;
  // Planned master response per channel: 0 ok, 1 nack, 2 no answer.
  int          r_kind [NUM_CH];
  int          r_dly  [NUM_CH];
  logic [15:0] r_dat  [NUM_CH];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] addr_of(input int i);
    logic [7*NUM_CH-1:0] t;
    t = ADDR_TABLE;
    return t[7*i +: 7];
  endfunction

  function automatic logic [63:0] exp_data_a();
    logic [63:0] r;
    for (int i = 0; i < NUM_CH; i++) r[8*i +: 8] = m_data[i][15:8];
    return r;
  endfunction

  function automatic logic [127:0] exp_data_b();
    logic [127:0] r;
    for (int i = 0; i < NUM_CH; i++) r[16*i +: 16] = m_data[i];
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_CH; i++) m_data[i] = 16'h0;
    m_valid = 8'h0;
    m_err   = 8'h0;
  endtask

  task automatic set_all_ok(input logic [15:0] dat);
    for (int i = 0; i < NUM_CH; i++) begin
      r_kind[i] = 0;
      r_dly[i]  = $urandom_range(0, 7);
      r_dat[i]  = dat;
    end
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_ctl_a"}, {start_a, addr_a, rw_a, swd_a, busy_a, valid_a, err_a}, 128'd0);
    check({tag, "_ctl_b"}, {start_b, addr_b, rw_b, swd_b, busy_b, valid_b, err_b}, 128'd0);
    check({tag, "_data_a"}, data_a, 128'd0);
    check({tag, "_data_b"}, data_b, 128'd0);
    check({tag, "_two_bytes"}, {tb_a, tb_b}, 2'b01);
  endtask

  // Act as the master for one transaction; entered on the first XFER cycle.
  task automatic serve(input int ch, input bit drop_en);
    logic [6:0] ea;
    int d, kind;
    ea   = addr_of(ch);
    kind = r_kind[ch];
    d    = (kind == 2) ? TIMEOUT - 1 : r_dly[ch];
    check("addr_a", addr_a, ea);
    check("addr_b", addr_b, ea);
    check("two_bytes", {tb_a, tb_b}, 2'b01);
    if (drop_en) enable = 1'b0;
    for (int k = 0; k <= d; k++) begin
      if (k > 0) check("start_one_cycle", {start_a, start_b}, 2'b00);
      check("addr_stable", {addr_a, addr_b, rw_a, rw_b}, {ea, ea, 2'b11});
      check("no_early_update", {valid_a[ch], err_a[ch], valid_b[ch], err_b[ch]},
            {m_valid[ch], m_err[ch], m_valid[ch], m_err[ch]});
      if (k == d && kind != 2) begin
        mst_done  = 1'b1;
        mst_nack  = (kind == 1);
        mst_rdata = (kind == 1) ? 16'($urandom) : r_dat[ch];
      end
      mst_ready = 1'($urandom);
      @(negedge clk);
      mst_done  = 1'b0;
      mst_nack  = 1'($urandom);
      mst_rdata = 16'($urandom);
    end
    if (kind == 0) begin
      m_data[ch]  = r_dat[ch];
      m_valid[ch] = 1'b1;
      m_err[ch]   = 1'b0;
    end else begin
      m_valid[ch] = 1'b0;
      m_err[ch]   = 1'b1;
    end
    check("start_low_after", {start_a, start_b}, 2'b00);
    check("result_a", {data_a[8*ch +: 8], valid_a[ch], err_a[ch]},
          {m_data[ch][15:8], m_valid[ch], m_err[ch]});
    check("result_b", {data_b[16*ch +: 16], valid_b[ch], err_b[ch]},
          {m_data[ch], m_valid[ch], m_err[ch]});
  endtask

  // One sweep, entered at a negedge in IDLE with the period counter at zero.
  task automatic do_sweep(input logic [7:0] mask, input int stop_ch, input bit scramble);
    int q[$];
    int idle_n, exp_starts, n_starts, n_swd, post, budget, ch;
    bit stopped, stop_active;
    stop_active = (stop_ch >= 0) && mask[stop_ch];
    exp_starts  = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (mask[i]) begin
        q.push_back(i);
        if (!stop_active || i <= stop_ch) exp_starts++;
      end
    end
    ch_mask = mask;
    enable  = 1'b1;
    idle_n  = 0;
    while (!busy_a && idle_n < 4 * POLL_PERIOD) begin
      check("rw_idle", {rw_a, rw_b}, 2'b00);
      if (idle_n > 0) check("sweep_done_width", {swd_a, swd_b}, 2'b00);
      idle_n++;
      mst_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    check("idle_len", idle_n, POLL_PERIOD);

    stopped  = 1'b0;
    n_starts = 0;
    n_swd    = 0;
    post     = 0;
    for (budget = 0; budget < 4000; budget++) begin
      mst_done = 1'b0;
      if (start_a || start_b) begin
        check("start_a", start_a, 1'b1);
        check("start_b", start_b, 1'b1);
        check("ready_before_start", mst_ready, 1'b1);
        n_starts++;
        if (q.size() > 0 && !stopped) begin
          ch = q.pop_front();
          serve(ch, ch == stop_ch);
          if (ch == stop_ch) stopped = 1'b1;
        end
      end
      if (swd_a || swd_b) begin
        check("sweep_done_a", swd_a, 1'b1);
        check("sweep_done_b", swd_b, 1'b1);
        n_swd++;
      end
      if (n_swd > 0 && !stopped) break;
      if (stopped) begin
        post++;
        if (post > 12) break;
      end
      if (scramble && busy_a) ch_mask = 8'($urandom);
      mst_ready = ($urandom_range(0, 3) != 0);
      // Stray completion outside XFER must be ignored.
      if ($urandom_range(0, 7) == 0) begin
        mst_done  = 1'b1;
        mst_nack  = 1'($urandom);
        mst_rdata = 16'($urandom);
      end
      @(negedge clk);
    end
    mst_done = 1'b0;
    check("sweep_in_budget", (budget < 4000), 1'b1);
    check("n_starts", n_starts, exp_starts);
    check("n_sweep_done", n_swd, stop_active ? 0 : 1);
    check("data_a", data_a, exp_data_a());
    check("data_b", data_b, exp_data_b());
    check("valid_err_a", {valid_a, err_a}, {m_valid, m_err});
    check("valid_err_b", {valid_b, err_b}, {m_valid, m_err});
    if (stop_active) check("busy_after_stop", {busy_a, busy_b}, 2'b00);
  endtask

  initial begin
    int n, u;
    rst       = 1'b0;
    enable    = 1'b0;
    ch_mask   = 8'h00;
    mst_ready = 1'b0;
    mst_done  = 1'b0;
    mst_nack  = 1'b0;
    mst_rdata = 16'h0;
    model_clear();
    repeat (3) @(negedge clk);
    mst_done  = 1'b1;
    mst_rdata = 16'hFFFF;
    @(negedge clk);
    mst_done  = 1'b0;
    reset_check("reset");
    rst = 1'b1;
    @(negedge clk);
    mst_done  = 1'b1;
    mst_rdata = 16'h1234;
    @(negedge clk);
    mst_done  = 1'b0;
    @(negedge clk);
    reset_check("idle_stray_done");

    set_all_ok(16'h1A00);
    do_sweep(8'hFF, -1, 1'b0);
    check("all_ch_1a", data_a, {8{8'h1A}});
    check("all_valid", valid_a, 8'hFF);

    r_dat[2] = 16'hBEEF;
    r_dat[3] = 16'h5500;
    do_sweep(8'hFF, -1, 1'b0);
    check("ch2_beef", data_b[47:32], 16'hBEEF);
    check("ch3_good", data_a[31:24], 8'h55);

    r_kind[3] = 1;
    do_sweep(8'hFF, -1, 1'b0);
    check("nack_keeps_data", data_a[31:24], 8'h55);
    check("nack_status", {valid_a[3], err_a[3]}, 2'b01);
    check("ch4_after_nack", {valid_a[4], err_a[4]}, 2'b10);

    set_all_ok(16'h3300);
    r_kind[0] = 2;
    do_sweep(8'h01, -1, 1'b0);
    check("timeout_status", {valid_a[0], err_a[0]}, 2'b01);
    r_kind[0] = 0;
    r_dly[0]  = TIMEOUT - 1;
    r_dat[0]  = 16'h7E00;
    do_sweep(8'h01, -1, 1'b0);
    check("late_done_wins", {valid_a[0], err_a[0], data_a[7:0]}, {2'b10, 8'h7E});

    do_sweep(8'h05, -1, 1'b0);
    do_sweep(8'h00, -1, 1'b0);
    do_sweep(8'hFF, 1, 1'b0);

    ch_mask   = 8'hFF;
    enable    = 1'b1;
    mst_ready = 1'b1;
    n = 0;
    while (!start_a && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("rst_mid_start_seen", start_a, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    reset_check("rst_mid_xfer");
    enable    = 1'b0;
    rst       = 1'b1;
    mst_done  = 1'b1;
    mst_nack  = 1'b0;
    mst_rdata = 16'hC3C3;
    @(negedge clk);
    mst_done = 1'b0;
    repeat (2) @(negedge clk);
    reset_check("done_after_rst");
    model_clear();

    for (int s = 0; s < 24; s++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        u         = $urandom_range(0, 9);
        r_kind[i] = (u < 7) ? 0 : (u < 9) ? 1 : 2;
        r_dly[i]  = $urandom_range(0, TIMEOUT - 1);
        r_dat[i]  = 16'($urandom);
      end
      do_sweep(8'($urandom), ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
